// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_decoder
//  Purpose  : PS/2 keyboard frame receiver that turns make/break scan codes
//             for W/S and the Up/Down arrows into held-key level vectors
//             for the left and right pads.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter logic [7:0]  CODE_L_UP      = 8'h1D,
  parameter logic [7:0]  CODE_L_DN      = 8'h1B,
  parameter logic [7:0]  CODE_R_UP      = 8'h75,
  parameter logic [7:0]  CODE_R_DN      = 8'h72
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] keys_left,
  output logic [1:0] keys_right,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [C_CNT_W-1:0] C_TO_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] C_EXT = 8'hE0;
  localparam logic [7:0] C_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchroniser stages and previous-clock register (idle-high lines)
  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;

  state_t             state_q, state_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_q, par_d;
  logic [C_CNT_W-1:0] tocnt_q, tocnt_d;
  logic               ext_q, ext_d;
  logic               brk_q, brk_d;
  logic [1:0]         kl_q, kl_d;
  logic [1:0]         kr_q, kr_d;
  logic               bv_q, bv_d;
  logic [7:0]         bd_q, bd_d;
  logic               fe_q, fe_d;

  logic w_fall;
  logic w_data;
  logic w_timeout;
  logic w_good;

  // Two-flop synchronisers on both PS/2 lines plus edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign w_fall    = clk_prev_q & ~clk_s2_q;
  assign w_data    = dat_s2_q;
  // A falling edge restarts the watchdog, so it only fires on a quiet line
  assign w_timeout = (state_q != S_IDLE) && !w_fall && (tocnt_q == C_TO_LAST);
  // Odd parity across the eight data bits and the parity bit, stop bit high
  assign w_good    = w_data & (^{shift_q, par_q});

  // Frame state, decode flags and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'd0;
      par_q    <= 1'b0;
      tocnt_q  <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      kl_q     <= 2'b00;
      kr_q     <= 2'b00;
      bv_q     <= 1'b0;
      bd_q     <= 8'd0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tocnt_q  <= tocnt_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      kl_q     <= kl_d;
      kr_q     <= kr_d;
      bv_q     <= bv_d;
      bd_q     <= bd_d;
      fe_q     <= fe_d;
    end
  end

  // Next-state: frame reception, watchdog and scan-code interpretation
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    kl_d     = kl_q;
    kr_d     = kr_q;
    bv_d     = 1'b0;
    bd_d     = bd_q;
    fe_d     = 1'b0;

    if ((state_q == S_IDLE) || w_fall) begin
      tocnt_d = '0;
    end else begin
      tocnt_d = tocnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // A high data line at a clock edge is not a start bit; ignore it
        if (w_fall && !w_data) begin
          state_d  = S_DATA;
          bitcnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          shift_d  = {w_data, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          par_d   = w_data;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          state_d = S_IDLE;
          if (w_good) begin
            bv_d = 1'b1;
            bd_d = shift_q;
            if (shift_q == C_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == C_BRK) begin
              brk_d = 1'b1;
            end else begin
              // Plain codes only drive the left pad, E0 codes only the right
              if (!ext_q) begin
                if (shift_q == CODE_L_UP) kl_d[1] = ~brk_q;
                if (shift_q == CODE_L_DN) kl_d[0] = ~brk_q;
              end else begin
                if (shift_q == CODE_R_UP) kr_d[1] = ~brk_q;
                if (shift_q == CODE_R_DN) kr_d[0] = ~brk_q;
              end
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            fe_d  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abandoned frame: drop partial data and any pending prefix
    if (w_timeout) begin
      state_d  = S_IDLE;
      fe_d     = 1'b1;
      bv_d     = 1'b0;
      shift_d  = 8'd0;
      bitcnt_d = 3'd0;
      tocnt_d  = '0;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
    end
  end

  assign keys_left  = kl_q;
  assign keys_right = kr_q;
  assign byte_valid = bv_q;
  assign byte_data  = bd_q;
  assign frame_err  = fe_q;

endmodule
`default_nettype wire
